// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   N-to-1 AXI write-path arbiter (AW, W, B) in front of one slave port.
//   AW: round-robin grant. W: locked to the granted master until w_last,
//   one burst in flight. B: routed back by the master-index prefix of m_b_id.
//
// Optional build macro: AXI_WR_ARB_QOS_EN
//   defined   -> arbitration only considers requesters carrying the highest
//                s_aw_qos among valid requesters, round-robin within that set.
//   undefined -> pure round-robin; qos only passes through to m_aw_qos.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_aw_*              per-master AW channels (flattened, master i at slice i)
//   s_w_*               per-master W channels
//   s_b_*               per-master B valid/ready, shared id/resp
//   m_aw_*              slave AW channel, m_aw_id = {grant index, s_aw_id}
//   m_w_*               slave W channel
//   m_b_*               slave B channel
//   err_len             sticky flag: W burst length did not match AW len
module axi_wr_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int AW_META_WIDTH = 24,
  localparam int IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                s_aw_valid,
  output logic [NUM_MASTERS-1:0]                s_aw_ready,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]       s_aw_id,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     s_aw_addr,
  input  logic [NUM_MASTERS*8-1:0]              s_aw_len,
  input  logic [NUM_MASTERS*4-1:0]              s_aw_qos,
  input  logic [NUM_MASTERS*AW_META_WIDTH-1:0]  s_aw_meta,
  input  logic [NUM_MASTERS-1:0]                s_w_valid,
  output logic [NUM_MASTERS-1:0]                s_w_ready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     s_w_data,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0]     s_w_strb,
  input  logic [NUM_MASTERS-1:0]                s_w_last,
  output logic [NUM_MASTERS-1:0]                s_b_valid,
  input  logic [NUM_MASTERS-1:0]                s_b_ready,
  output logic [ID_WIDTH-1:0]                   s_b_id,
  output logic [1:0]                            s_b_resp,
  output logic                                  m_aw_valid,
  input  logic                                  m_aw_ready,
  output logic [ID_WIDTH+IDX_W-1:0]             m_aw_id,
  output logic [ADDR_WIDTH-1:0]                 m_aw_addr,
  output logic [7:0]                            m_aw_len,
  output logic [3:0]                            m_aw_qos,
  output logic [AW_META_WIDTH-1:0]              m_aw_meta,
  output logic                                  m_w_valid,
  input  logic                                  m_w_ready,
  output logic [DATA_WIDTH-1:0]                 m_w_data,
  output logic [STRB_WIDTH-1:0]                 m_w_strb,
  output logic                                  m_w_last,
  input  logic                                  m_b_valid,
  output logic                                  m_b_ready,
  input  logic [ID_WIDTH+IDX_W-1:0]             m_b_id,
  input  logic [1:0]                            m_b_resp,
  output logic                                  err_len
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [7:0]       len_q, len_d;
  logic             err_len_q, err_len_d;

  // Per-master views of the flattened input buses.
  logic [ID_WIDTH-1:0]      aw_id_a   [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]    aw_addr_a [NUM_MASTERS];
  logic [7:0]               aw_len_a  [NUM_MASTERS];
  logic [3:0]               aw_qos_a  [NUM_MASTERS];
  logic [AW_META_WIDTH-1:0] aw_meta_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]    w_data_a  [NUM_MASTERS];
  logic [STRB_WIDTH-1:0]    w_strb_a  [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign aw_id_a[i]   = s_aw_id[i*ID_WIDTH +: ID_WIDTH];
    assign aw_addr_a[i] = s_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_len_a[i]  = s_aw_len[i*8 +: 8];
    assign aw_qos_a[i]  = s_aw_qos[i*4 +: 4];
    assign aw_meta_a[i] = s_aw_meta[i*AW_META_WIDTH +: AW_META_WIDTH];
    assign w_data_a[i]  = s_w_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_a[i]  = s_w_strb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  // ---------------- arbitration ----------------
  logic [NUM_MASTERS-1:0] cand;

`ifdef AXI_WR_ARB_QOS_EN
  logic [3:0] max_qos;
  always_comb begin
    max_qos = '0;
    cand    = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (s_aw_valid[i] && (aw_qos_a[i] > max_qos)) max_qos = aw_qos_a[i];
    for (int i = 0; i < NUM_MASTERS; i++)
      cand[i] = s_aw_valid[i] && (aw_qos_a[i] == max_qos);
  end
`else
  assign cand = s_aw_valid;
`endif

  logic [IDX_W-1:0] pick, scan_idx;
  logic             pick_vld;

  // Scan from the farthest offset back to rr_ptr so the candidate closest
  // to rr_ptr (cyclically) is the one left standing.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (cand[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // ---------------- handshakes ----------------
  logic aw_act, w_act, w_hs;
  assign aw_act = !rst && (state_q == ADDR);
  assign w_act  = !rst && (state_q == DATA);
  assign w_hs   = w_act && s_w_valid[grant_q] && m_w_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_len_q  <= err_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    err_len_d  = err_len_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_aw_ready) begin
          len_d      = aw_len_a[grant_q];
          beat_cnt_d = '0;
          rr_ptr_d   = (int'(grant_q) == NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (s_w_last[grant_q]) begin
            state_d = IDLE;
            if (beat_cnt_q != len_q) err_len_d = 1'b1;
          end else if (beat_cnt_q == len_q) begin
            // Beat len should have carried w_last; keep draining until it does.
            err_len_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- AW / W outputs ----------------
  assign m_aw_valid = aw_act;
  assign m_aw_id    = {grant_q, aw_id_a[grant_q]};
  assign m_aw_addr  = aw_addr_a[grant_q];
  assign m_aw_len   = aw_len_a[grant_q];
  assign m_aw_qos   = aw_qos_a[grant_q];
  assign m_aw_meta  = aw_meta_a[grant_q];

  assign m_w_valid  = w_act && s_w_valid[grant_q];
  assign m_w_data   = w_data_a[grant_q];
  assign m_w_strb   = w_strb_a[grant_q];
  assign m_w_last   = s_w_last[grant_q];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_rdy
    assign s_aw_ready[i] = aw_act && (grant_q == IDX_W'(i)) && m_aw_ready;
    assign s_w_ready[i]  = w_act  && (grant_q == IDX_W'(i)) && m_w_ready;
  end

  assign err_len = err_len_q;

  // ---------------- B routing (stateless) ----------------
  logic [IDX_W-1:0] b_sel;
  logic             b_sel_ok;
  assign b_sel    = m_b_id[ID_WIDTH +: IDX_W];
  assign b_sel_ok = int'(b_sel) < NUM_MASTERS;
  // Responses carrying an index with no master behind it are sunk.
  assign m_b_ready = b_sel_ok ? s_b_ready[b_sel] : 1'b1;
  assign s_b_id    = m_b_id[ID_WIDTH-1:0];
  assign s_b_resp  = m_b_resp;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_b
    assign s_b_valid[i] = m_b_valid && (b_sel == IDX_W'(i));
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter (2 masters, default widths).
module tb_axi_wr_arbiter;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   s_aw_valid, s_aw_ready;
  logic [7:0]   s_aw_id;
  logic [63:0]  s_aw_addr;
  logic [15:0]  s_aw_len;
  logic [7:0]   s_aw_qos;
  logic [47:0]  s_aw_meta;
  logic [1:0]   s_w_valid, s_w_ready;
  logic [127:0] s_w_data;
  logic [15:0]  s_w_strb;
  logic [1:0]   s_w_last;
  logic [1:0]   s_b_valid, s_b_ready;
  logic [3:0]   s_b_id;
  logic [1:0]   s_b_resp;
  logic         m_aw_valid, m_aw_ready;
  logic [4:0]   m_aw_id;
  logic [31:0]  m_aw_addr;
  logic [7:0]   m_aw_len;
  logic [3:0]   m_aw_qos;
  logic [23:0]  m_aw_meta;
  logic         m_w_valid, m_w_ready;
  logic [63:0]  m_w_data;
  logic [7:0]   m_w_strb;
  logic         m_w_last;
  logic         m_b_valid, m_b_ready;
  logic [4:0]   m_b_id;
  logic [1:0]   m_b_resp;
  logic         err_len;

  axi_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_qos(s_aw_qos),
    .s_aw_meta(s_aw_meta),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id),
    .s_b_resp(s_b_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
    .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_qos(m_aw_qos),
    .m_aw_meta(m_aw_meta),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id),
    .m_b_resp(m_b_resp),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // Bench-side master state: beat counter, burst len, optional early w_last.
  int wcnt[N];
  int wlen[N];
  int early[N];
  bit oneshot;   // drop s_aw_valid after its handshake
  bit toggle;    // toggle m_w_ready every cycle

  // Values sampled just before each active edge.
  logic        sp_aw_hs, sp_w_hs, sp_w_last, sp_m_aw_valid, sp_m_w_valid, sp_err;
  logic [4:0]  sp_aw_id;
  logic [31:0] sp_aw_addr;
  logic [7:0]  sp_aw_len;
  logic [3:0]  sp_aw_qos;
  logic [63:0] sp_w_data;
  logic [1:0]  sp_saw_rdy, sp_sw_rdy, sw_hs, saw_hs;

  int gq[$];   // grant order
  int bq[$];   // beats per completed burst

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] id_of(input int m);
    return (m == 0) ? 4'h3 : 4'h5;
  endfunction
  function automatic logic [3:0] qos_of(input int m);
    return (m == 0) ? 4'd2 : 4'd9;
  endfunction
  function automatic logic [31:0] addr_of(input int m);
    return (m == 0) ? 32'h1000 : 32'h2000;
  endfunction

  task automatic drive_w();
    for (int i = 0; i < N; i++) begin
      s_w_last[i] = (early[i] >= 0) ? (wcnt[i] == early[i]) : (wcnt[i] == wlen[i]);
      s_w_data[i*64 +: 64] = {32'(i + 1), 32'(wcnt[i])};
      s_aw_len[i*8 +: 8] = 8'(wlen[i]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sp_aw_hs      = m_aw_valid && m_aw_ready;
    sp_w_hs       = m_w_valid && m_w_ready;
    sp_aw_id      = m_aw_id;
    sp_aw_addr    = m_aw_addr;
    sp_aw_len     = m_aw_len;
    sp_aw_qos     = m_aw_qos;
    sp_w_data     = m_w_data;
    sp_w_last     = m_w_last;
    sp_m_aw_valid = m_aw_valid;
    sp_m_w_valid  = m_w_valid;
    sp_err        = err_len;
    sp_saw_rdy    = s_aw_ready;
    sp_sw_rdy     = s_w_ready;
    sw_hs         = s_w_valid & s_w_ready;
    saw_hs        = s_aw_valid & s_aw_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sw_hs[i]) wcnt[i] = s_w_last[i] ? 0 : wcnt[i] + 1;
      if (saw_hs[i] && oneshot) s_aw_valid[i] = 1'b0;
    end
    if (toggle) m_w_ready = ~m_w_ready;
    drive_w();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_aw_valid = '0;
    s_w_valid = '0;
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0;
      early[i] = -1;
    end
    drive_w();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gq.delete();
    bq.delete();
  endtask

  // Monitor nb bursts on the slave side, checking AW fields and W payload order.
  task automatic run(input int nb, input int budget);
    int done = 0;
    int beats = 0;
    int cur = 0;
    int n = 0;
    while (done < nb && n < budget) begin
      cyc();
      n++;
      if (sp_aw_hs) begin
        cur = int'(sp_aw_id[4]);
        gq.push_back(cur);
        chk("aw_id_low", 64'(sp_aw_id[3:0]), 64'(id_of(cur)));
        chk("aw_addr", 64'(sp_aw_addr), 64'(addr_of(cur)));
        chk("aw_qos", 64'(sp_aw_qos), 64'(qos_of(cur)));
        chk("aw_len", 64'(sp_aw_len), 64'(wlen[cur]));
        chk("s_aw_ready_onehot", 64'(sp_saw_rdy), 64'(2'b01 << cur));
        beats = 0;
      end
      if (sp_w_hs) begin
        chk("w_data", sp_w_data, {32'(cur + 1), 32'(beats)});
        chk("s_w_ready_onehot", 64'(sp_sw_rdy), 64'(2'b01 << cur));
        beats++;
        if (sp_w_last) begin
          bq.push_back(beats);
          done++;
        end
      end
    end
    if (done < nb) chk("burst_timeout", 64'(done), 64'(nb));
  endtask

  typedef struct {
    logic       bv;
    logic [4:0] bid;
    logic [1:0] resp;
    logic [1:0] srdy;
    logic [1:0] e_sbv;
    logic       e_mbr;
    logic [3:0] e_sid;
  } bvec_t;
  bvec_t bt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // B-path vectors: {valid, m_b_id, resp, s_b_ready, exp s_b_valid, exp m_b_ready, exp s_b_id}
    bt[0] = '{1'b1, 5'h1A, 2'd0, 2'b00, 2'b10, 1'b0, 4'hA};
    bt[1] = '{1'b1, 5'h1A, 2'd0, 2'b01, 2'b10, 1'b0, 4'hA};
    bt[2] = '{1'b1, 5'h1A, 2'd0, 2'b00, 2'b10, 1'b0, 4'hA};
    bt[3] = '{1'b1, 5'h1A, 2'd0, 2'b10, 2'b10, 1'b1, 4'hA};
    bt[4] = '{1'b1, 5'h05, 2'd2, 2'b01, 2'b01, 1'b1, 4'h5};
    bt[5] = '{1'b1, 5'h05, 2'd2, 2'b10, 2'b01, 1'b0, 4'h5};
    bt[6] = '{1'b0, 5'h1A, 2'd1, 2'b10, 2'b00, 1'b1, 4'hA};
    bt[7] = '{1'b1, 5'h1F, 2'd3, 2'b11, 2'b10, 1'b1, 4'hF};

    s_aw_id   = {4'h5, 4'h3};
    s_aw_addr = {32'h2000, 32'h1000};
    s_aw_qos  = {4'd9, 4'd2};
    s_aw_meta = {24'hBBBBBB, 24'hAAAAAA};
    s_w_strb  = '1;
    s_b_ready = '0;
    m_b_valid = 1'b0;
    m_b_id    = '0;
    m_b_resp  = '0;
    oneshot = 1'b0;
    toggle  = 1'b0;
    for (int i = 0; i < N; i++) begin
      wcnt[i] = 0;
      wlen[i] = 3;
      early[i] = -1;
    end
    drive_w();

    // ---- outputs held inactive during reset, even with requests present ----
    rst = 1'b1;
    s_aw_valid = 2'b11;
    s_w_valid  = 2'b11;
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst_m_aw_valid", 64'(sp_m_aw_valid), 64'd0);
      chk("rst_m_w_valid", 64'(sp_m_w_valid), 64'd0);
      chk("rst_s_aw_ready", 64'(sp_saw_rdy), 64'd0);
      chk("rst_s_w_ready", 64'(sp_sw_rdy), 64'd0);
    end
    chk("rst_err_len", 64'(sp_err), 64'd0);

    // ---- both masters request continuously, len=3 ----
    rst = 1'b0;
    gq.delete();
    bq.delete();
    run(4, 100);
    s_aw_valid = '0;
    s_w_valid  = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef AXI_WR_ARB_QOS_EN
      chk("rr_grant", 64'((k < gq.size()) ? gq[k] : -1), 64'd1);
`else
      chk("rr_grant", 64'((k < gq.size()) ? gq[k] : -1), 64'(k % 2));
`endif
      chk("rr_beats", 64'((k < bq.size()) ? bq[k] : -1), 64'd4);
    end
    cyc();
    chk("rr_err_len", 64'(sp_err), 64'd0);

    // ---- W valid before AW: held off until AW handshake ----
    do_reset();
    oneshot = 1'b1;
    s_w_valid = 2'b10;
    repeat (5) begin
      cyc();
      chk("early_w_s_w_ready1", 64'(sp_sw_rdy[1]), 64'd0);
      chk("early_w_m_w_valid", 64'(sp_m_w_valid), 64'd0);
    end
    s_aw_valid = 2'b10;
    run(1, 30);
    chk("early_w_grant", 64'((gq.size() > 0) ? gq[0] : -1), 64'd1);
    chk("early_w_beats", 64'((bq.size() > 0) ? bq[0] : -1), 64'd4);
    s_w_valid = '0;

    // ---- m_w_ready toggling over a len=7 burst ----
    do_reset();
    wlen[0] = 7;
    drive_w();
    s_w_valid  = 2'b01;
    s_aw_valid = 2'b01;
    m_w_ready  = 1'b1;
    toggle = 1'b1;
    run(1, 60);
    toggle = 1'b0;
    m_w_ready = 1'b1;
    chk("toggle_beats", 64'((bq.size() > 0) ? bq[0] : -1), 64'd8);
    // Master keeps W valid but has no AW: nothing more may pass.
    repeat (4) begin
      cyc();
      chk("toggle_no_extra_m_w_valid", 64'(sp_m_w_valid), 64'd0);
      chk("toggle_no_extra_s_w_ready", 64'(sp_sw_rdy), 64'd0);
    end
    chk("toggle_err_len", 64'(sp_err), 64'd0);
    s_w_valid = '0;
    wlen[0] = 3;

    // ---- short burst: w_last on beat 2 of len=3 ----
    do_reset();
    early[0] = 2;
    drive_w();
    s_w_valid  = 2'b01;
    s_aw_valid = 2'b01;
    run(1, 30);
    chk("short_beats", 64'((bq.size() > 0) ? bq[0] : -1), 64'd3);
    cyc();
    chk("short_err_len", 64'(sp_err), 64'd1);
    chk("short_idle_m_w_valid", 64'(sp_m_w_valid), 64'd0);
    // A correct burst afterwards leaves the flag set.
    early[0] = -1;
    drive_w();
    s_aw_valid = 2'b01;
    bq.delete();
    run(1, 30);
    chk("sticky_beats", 64'((bq.size() > 0) ? bq[0] : -1), 64'd4);
    cyc();
    chk("sticky_err_len", 64'(sp_err), 64'd1);
    s_w_valid = '0;
    do_reset();
    cyc();
    chk("reset_clears_err_len", 64'(sp_err), 64'd0);

    // ---- B routing vectors ----
    for (int v = 0; v < 8; v++) begin
      m_b_valid = bt[v].bv;
      m_b_id    = bt[v].bid;
      m_b_resp  = bt[v].resp;
      s_b_ready = bt[v].srdy;
      @(negedge clk);
      chk($sformatf("b%0d_s_b_valid", v), 64'(s_b_valid), 64'(bt[v].e_sbv));
      chk($sformatf("b%0d_m_b_ready", v), 64'(m_b_ready), 64'(bt[v].e_mbr));
      chk($sformatf("b%0d_s_b_id", v), 64'(s_b_id), 64'(bt[v].e_sid));
      chk($sformatf("b%0d_s_b_resp", v), 64'(s_b_resp), 64'(bt[v].resp));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
